// File: rtl/cdnsusbhs_clkgate_ctrl.sv
`default_nettype none
// cdnsusbhs_clkgate_ctrl: per-channel clock-gate enables with an idle timeout,
// a settle delay on wake, and a four-phase wake_req/wake_ack handshake.
module cdnsusbhs_clkgate_ctrl #(
  parameter int NCH    = 4,
  parameter int IDLEW  = 8,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       busy,
  input  logic [NCH-1:0]       wake_req,
  input  logic [NCH-1:0]       force_on,
  input  logic [NCH*IDLEW-1:0] idle_limit,
  output logic [NCH-1:0]       gate_en,
  output logic [NCH-1:0]       wake_ack,
  output logic                 all_gated
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [IDLEW-1:0] idle_cnt, idle_cnt_nxt;
    logic [IDLEW-1:0] limit;
    logic [3:0]       settle_cnt, settle_cnt_nxt;
    logic             active;
    logic             expire;
    logic             gate_r;
    logic             ack_r;

    assign limit  = idle_limit[i*IDLEW +: IDLEW];
    assign active = busy[i] | wake_req[i] | force_on[i];
    // Compare one bit wider so count+1 at all-ones cannot wrap below the limit.
    assign expire = (limit != '0) &&
                    (({1'b0, idle_cnt} + {{IDLEW{1'b0}}, 1'b1}) >= {1'b0, limit});

    always_comb begin
      state_nxt      = state;
      idle_cnt_nxt   = idle_cnt;
      settle_cnt_nxt = settle_cnt;
      case (state)
        ST_ON: begin
          if (active) begin
            idle_cnt_nxt = '0;
          end else if (expire) begin
            state_nxt    = ST_OFF;
            idle_cnt_nxt = '0;
          end else if (idle_cnt != '1) begin
            idle_cnt_nxt = idle_cnt + IDLEW'(1);
          end
        end
        ST_OFF: begin
          if (active) begin
            state_nxt      = ST_WAKE;
            settle_cnt_nxt = SETTLE_LOAD;
          end
        end
        ST_WAKE: begin
          idle_cnt_nxt = '0;
          if (settle_cnt == 4'd0) begin
            state_nxt = ST_ON;
          end else begin
            settle_cnt_nxt = settle_cnt - 4'd1;
          end
        end
        default: begin
          state_nxt = ST_ON;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state      <= ST_ON;
        idle_cnt   <= '0;
        settle_cnt <= 4'd0;
        gate_r     <= 1'b1;
        ack_r      <= 1'b0;
      end else begin
        state      <= state_nxt;
        idle_cnt   <= idle_cnt_nxt;
        settle_cnt <= settle_cnt_nxt;
        gate_r     <= (state_nxt != ST_OFF);
        ack_r      <= (state_nxt == ST_ON) & wake_req[i];
      end
    end

    assign gate_en[i]  = gate_r;
    assign wake_ack[i] = ack_r;
  end

  assign all_gated = ~|gate_en;

endmodule
`default_nettype wire

// File: doc/cdnsusbhs_clkgate_ctrl.md
# cdnsusbhs_clkgate_ctrl

Parametrised multi-channel clock-gating controller. It generates registered enable signals for the global clock-gating cells that drive the controller's clock domains. Each channel has an idle-timeout counter and a wake request/acknowledge handshake, so a domain's clock is stopped after a programmable period of inactivity and is restored, with a settle delay, on demand.

## Interface

Parameters:
- NCH, 4 — number of independent gated clock channels (1..16).
- IDLEW, 8 — width of each channel's idle counter and idle limit.
- SETTLE, 2 — cycles a channel spends in WAKE before it is reported ON (1..15).

Ports:
- clk  in  1  controller clock; all state sampled on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- busy  in  NCH  per-channel activity indication, level.
- wake_req  in  NCH  per-channel clock request, level, four-phase with wake_ack.
- force_on  in  NCH  per-channel override; keeps the clock running.
- idle_limit  in  NCH*IDLEW  per-channel idle timeout in cycles; channel i uses bits [i*IDLEW +: IDLEW]; 0 disables gating.
- gate_en  out  NCH  registered enable to the clock-gating cell; 1 means clock running.
- wake_ack  out  NCH  registered acknowledge; high while channel is ON and wake_req is high.
- all_gated  out  1  high when every gate_en bit is 0.

## Operation

- Each channel has its own FSM with states OFF, WAKE and ON, plus an IDLEW-bit idle counter and a 4-bit settle counter. The channels are fully independent.
- A channel is "active" when busy | wake_req | force_on.
- **ON**:
  - gate_en=1.
  - When active, the idle counter clears to 0.
  - When inactive, the idle counter increments and saturates at all-ones.
  - Transition to OFF happens at the edge where the channel is inactive, idle_limit != 0, and idle counter + 1 >= idle_limit. The counter clears on that transition.
- **OFF**:
  - gate_en=0.
  - When active, transition to WAKE and load the settle counter with SETTLE-1.
- **WAKE**:
  - gate_en=1.
  - The settle counter decrements each cycle. At 0, transition to ON.
  - Activity is ignored; WAKE always completes to ON.
  - The idle counter is held at 0.
- wake_ack register is loaded with (next_state==ON) & wake_req. After a WAKE, wake_ack therefore rises on the same edge the channel enters ON.
- Handshake rules:
  - The requester holds wake_req until it sees wake_ack=1, then drops it.
  - wake_ack falls on the next edge.
  - A new request must not be raised until wake_ack=0.
- idle_limit may change at any time; the >= compare applies the new value immediately. A limit lowered below the current count gates on the next inactive sample.
- force_on=1 in OFF wakes the channel like wake_req does. In ON, force_on prevents gating.
- all_gated = ~|gate_en.

## Timing

- Reset values: state ON, gate_en all 1, wake_ack all 0, all_gated 0, all counters 0.
- Asserting rst_n at any time, including mid-WAKE or mid-count, asynchronously forces these values.
- Gating latency: with idle_limit=L, the channel first samples inactive at edge e. gate_en falls after edge e+L-1, i.e. the L-th consecutive inactive sample.
- Wake latency: wake_req is first sampled high in OFF at edge k.
  - gate_en=1 after edge k.
  - Channel ON and wake_ack=1 after edge k+SETTLE.
- wake_req sampled high while already ON: wake_ack=1 after the same edge (1-cycle latency).
- busy alone in OFF wakes the channel. No ack is issued.
- A busy pulse while ON restarts the full idle_limit count from its falling edge.
- Inactive and active samples are evaluated at the same edge; activity takes priority, so the channel does not gate.

## Test plan

Configuration for all scenarios: NCH=2, IDLEW=4, SETTLE=3.

- **Reset then idle:** release rst_n with idle_limit={4'd0,4'd5} and no activity -> gate_en=2'b11 and wake_ack=0 at release. gate_en[0] falls after the 5th edge; gate_en[1] stays 1 for 100 cycles; all_gated stays 0.
- **Wake handshake:** ch0 OFF, wake_req[0] raised before edge k -> gate_en[0]=1 after k, wake_ack[0]=1 after k+3. Drop wake_req[0] -> wake_ack[0]=0 after the next edge. Channel then gates 5 inactive cycles later.
- **Activity restart:** ch0 ON, idle_limit=5, busy[0] pulsed for 1 cycle after 4 inactive samples -> no gating. gate_en[0] falls 5 edges after busy drops.
- **All gated and force:** both limits set to 3, no activity -> all_gated=1 after edge 3. force_on[1]=1 -> gate_en[1]=1 next edge and ON after 3 more; all_gated=0 and stays 0 while force_on is held.
- **Limit change and simultaneity:**
  - ch0 idle count at 6 with limit 10; write limit=4 -> gates on the next inactive edge.
  - Wake and idle events on both channels at the same edge -> each channel follows its own rules independently.
- **Reset mid-operation:** assert rst_n with ch0 in WAKE (settle=1) and ch1 OFF -> gate_en=2'b11 and wake_ack=0 immediately, without waiting for a clock edge. After release, both channels are ON with counters 0.
